// File: rtl/pic_pkg.sv
// pic_pkg: shared control-word flag codes, read-select codes and init FSM states
package pic_pkg;
    localparam logic [2:0] FLAG_ICW1 = 3'd0;
    localparam logic [2:0] FLAG_ICW2 = 3'd1;
    localparam logic [2:0] FLAG_ICW3 = 3'd2;
    localparam logic [2:0] FLAG_ICW4 = 3'd3;
    localparam logic [2:0] FLAG_OCW1 = 3'd4;
    localparam logic [2:0] FLAG_OCW2 = 3'd5;
    localparam logic [2:0] FLAG_OCW3 = 3'd6;
    localparam logic [2:0] FLAG_IDLE = 3'd7;
    localparam logic [2:0] RSEL_IRR  = 3'b001;
    localparam logic [2:0] RSEL_ISR  = 3'b101;
    localparam logic [2:0] RSEL_IMR  = 3'b011;
    localparam logic [2:0] RSEL_NONE = 3'b000;
    typedef enum logic [2:0] {WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} pic_state_t;
endpackage

// File: rtl/pic_sync.sv
// pic_sync: multi-flop synchroniser with synchronous reset to a fixed value
module pic_sync #(
    parameter int W = 1,
    parameter int STAGES = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stg [STAGES];
    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) stg[i] <= RST_VAL;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
        end
    end
    assign q = stg[STAGES-1];
endmodule

// File: rtl/pic_rw_sequencer.sv
// pic_rw_sequencer: bus synchronisation, ICW/OCW classification and read-select for an 8259-style PIC
module pic_rw_sequencer import pic_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CS_n,
    input  logic              WR_n,
    input  logic              RD_n,
    input  logic              A0,
    input  logic [DATA_W-1:0] D_in,
    output logic [2:0]        cw_flag,
    output logic [DATA_W-1:0] cw_data,
    output logic [2:0]        read_select,
    output logic              init_done,
    output logic              sngl,
    output logic              ic4
);
    logic s_cs_n, s_wr_n, s_rd_n, s_a0;
    logic [DATA_W-1:0] s_d;
    logic p_cs_n, p_wr_n, p_a0;
    logic [DATA_W-1:0] p_d;
    logic commit, rr_isr, nxt_rr_isr, nxt_sngl, nxt_ic4;
    logic [2:0] nxt_flag;
    pic_state_t state, nxt_state;

    pic_sync #(.W(3), .STAGES(SYNC_STAGES), .RST_VAL(3'b111)) u_strb (
        .clk(clk), .reset(reset), .d({CS_n, WR_n, RD_n}), .q({s_cs_n, s_wr_n, s_rd_n})
    );
    pic_sync #(.W(DATA_W+1), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_data (
        .clk(clk), .reset(reset), .d({A0, D_in}), .q({s_a0, s_d})
    );

    // keep the previous synchronised bus so a WR_n rising edge commits the values seen while it was low
    always_ff @(posedge clk) begin
        if (reset) begin
            p_cs_n <= 1'b1;
            p_wr_n <= 1'b1;
            p_a0   <= 1'b0;
            p_d    <= '0;
        end else begin
            p_cs_n <= s_cs_n;
            p_wr_n <= s_wr_n;
            p_a0   <= s_a0;
            p_d    <= s_d;
        end
    end

    assign commit = s_wr_n & ~p_wr_n & ~p_cs_n;

    // classify a committed write and pick the next init state; ICW1 always restarts the sequence
    always_comb begin
        nxt_state  = state;
        nxt_flag   = FLAG_IDLE;
        nxt_sngl   = sngl;
        nxt_ic4    = ic4;
        nxt_rr_isr = rr_isr;
        if (commit) begin
            if (!p_a0 && p_d[4]) begin
                nxt_state = WAIT_ICW2;
                nxt_flag  = FLAG_ICW1;
                nxt_sngl  = p_d[1];
                nxt_ic4   = p_d[0];
            end else if (p_a0) begin
                case (state)
                    WAIT_ICW2: begin
                        nxt_flag  = FLAG_ICW2;
                        nxt_state = !sngl ? WAIT_ICW3 : ic4 ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW3: begin
                        nxt_flag  = FLAG_ICW3;
                        nxt_state = ic4 ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: begin
                        nxt_flag  = FLAG_ICW4;
                        nxt_state = READY;
                    end
                    READY:     nxt_flag = FLAG_OCW1;
                    default:   nxt_flag = FLAG_IDLE;
                endcase
            end else if (state == READY) begin
                nxt_flag = p_d[3] ? FLAG_OCW3 : FLAG_OCW2;
                if (p_d[3] && p_d[1]) nxt_rr_isr = p_d[0];
            end
        end
    end

    // register FSM state, the one-cycle flag with its data, mode bits and the read-source decode
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_ICW1;
            cw_flag     <= FLAG_IDLE;
            cw_data     <= '0;
            init_done   <= 1'b0;
            sngl        <= 1'b0;
            ic4         <= 1'b0;
            rr_isr      <= 1'b0;
            read_select <= RSEL_NONE;
        end else begin
            state       <= nxt_state;
            cw_flag     <= nxt_flag;
            if (nxt_flag != FLAG_IDLE) cw_data <= p_d;
            init_done   <= nxt_state == READY;
            sngl        <= nxt_sngl;
            ic4         <= nxt_ic4;
            rr_isr      <= nxt_rr_isr;
            read_select <= (!s_cs_n && !s_rd_n && s_wr_n) ? (s_a0 ? RSEL_IMR : rr_isr ? RSEL_ISR : RSEL_IRR) : RSEL_NONE;
        end
    end
endmodule

// File: tb/tb_pic_rw_sequencer.sv
// tb_pic_rw_sequencer: directed and randomised bus traffic checked against a queue-based init model
module tb_pic_rw_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic CS_n = 1'b1, WR_n = 1'b1, RD_n = 1'b1, A0 = 1'b0;
    logic [7:0] D_in = 8'h00;
    logic [2:0] cw_flag, read_select;
    logic [7:0] cw_data;
    logic init_done, sngl, ic4;

    int n_chk = 0;
    int n_fail = 0;

    bit m_cfg, m_sngl, m_ic4, m_done, m_isr;
    logic [7:0] m_data;
    logic [2:0] m_q[$];

    bit logging = 0;
    logic [2:0] flog[$];

    pic_rw_sequencer #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n), .A0(A0), .D_in(D_in),
        .cw_flag(cw_flag), .cw_data(cw_data), .read_select(read_select),
        .init_done(init_done), .sngl(sngl), .ic4(ic4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (logging) flog.push_back(cw_flag);

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cfg = 0; m_sngl = 0; m_ic4 = 0; m_done = 0; m_isr = 0; m_data = 8'h00;
        m_q.delete();
    endtask

    // after ICW1 the remaining ICWs are simply a queue of codes still owed
    task automatic model_write(input bit cs, input bit a0v, input logic [7:0] dv, output logic [2:0] f);
        f = 3'd7;
        if (!cs) begin
            if (!a0v && dv[4]) begin
                f = 3'd0; m_cfg = 1; m_sngl = dv[1]; m_ic4 = dv[0]; m_done = 0;
                m_q.delete();
                m_q.push_back(3'd1);
                if (!dv[1]) m_q.push_back(3'd2);
                if (dv[0]) m_q.push_back(3'd3);
            end else if (!m_cfg) begin
                f = 3'd7;
            end else if (m_q.size() != 0) begin
                if (a0v) begin
                    f = m_q.pop_front();
                    m_done = (m_q.size() == 0);
                end
            end else if (a0v) begin
                f = 3'd4;
            end else begin
                f = dv[3] ? 3'd6 : 3'd5;
                if (dv[3] && dv[1]) m_isr = dv[0];
            end
        end
        if (f != 3'd7) m_data = dv;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cw_data"}, cw_data, m_data);
        check({tag, "_init_done"}, 8'(init_done), 8'(m_done));
        check({tag, "_sngl"}, 8'(sngl), 8'(m_sngl));
        check({tag, "_ic4"}, 8'(ic4), 8'(m_ic4));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flag"}, 8'(cw_flag), 8'd7);
        check({tag, "_data"}, cw_data, 8'h00);
        check({tag, "_rsel"}, 8'(read_select), 8'd0);
        check({tag, "_init"}, 8'(init_done), 8'd0);
        check({tag, "_sngl"}, 8'(sngl), 8'd0);
        check({tag, "_ic4"}, 8'(ic4), 8'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input bit cs, input bit a0v, input logic [7:0] dv, input bit with_rd);
        logic [2:0] ef;
        CS_n = cs; A0 = a0v; D_in = dv; WR_n = 1'b0; RD_n = !with_rd;
        repeat (4) @(posedge clk);
        if (with_rd) begin
            @(negedge clk);
            check("rsel_rd_wr", 8'(read_select), 8'd0);
            @(posedge clk);
        end
        #1 WR_n = 1'b1;
        model_write(cs, a0v, dv, ef);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("cw_flag", 8'(cw_flag), (i == 4) ? 8'(ef) : 8'd7);
        end
        check_state("wr");
        @(posedge clk);
        #1 CS_n = 1'b1; RD_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input bit a0v);
        CS_n = 1'b0; A0 = a0v; RD_n = 1'b0; WR_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rsel_read", 8'(read_select), a0v ? 8'h03 : (m_isr ? 8'h05 : 8'h01));
        @(posedge clk);
        #1 CS_n = 1'b1; RD_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rsel_idle", 8'(read_select), 8'h00);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] bw [3];
        logic [2:0] ef;
        logic [2:0] exp_q[$];
        int idx[$];
        bw = '{9'h013, 9'h120, 9'h101};
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;

        // back-to-back ICW1/ICW2/ICW4, one write every third cycle
        do_reset();
        logging = 1;
        foreach (bw[j]) begin
            CS_n = 1'b0; A0 = bw[j][8]; D_in = bw[j][7:0]; WR_n = 1'b0;
            @(posedge clk);
            #1 WR_n = 1'b1;
            model_write(1'b0, bw[j][8], bw[j][7:0], ef);
            exp_q.push_back(ef);
            repeat (2) @(posedge clk);
            #1;
        end
        repeat (6) @(posedge clk);
        #1 logging = 0; CS_n = 1'b1;
        foreach (flog[i]) if (flog[i] != 3'd7) idx.push_back(i);
        check("burst_count", 8'(idx.size()), 8'd3);
        for (int k = 0; k < idx.size() && k < 3; k++) begin
            check("burst_code", 8'(flog[idx[k]]), 8'(exp_q[k]));
            if (k > 0) check("burst_gap", 8'(idx[k] - idx[k-1]), 8'd3);
        end
        check_state("burst");

        // cascade init without ICW4, then operational words and reads
        do_reset();
        bus_write(0, 0, 8'h10, 0);
        bus_write(0, 1, 8'h08, 0);
        bus_write(0, 1, 8'h04, 0);
        bus_write(0, 1, 8'hFB, 0);
        bus_write(0, 0, 8'h20, 0);
        bus_write(0, 0, 8'h0B, 0);
        bus_read(0);
        bus_read(1);

        // dropped write in WAIT_ICW3, then ICW1 restart
        bus_write(0, 0, 8'h11, 0);
        bus_write(0, 1, 8'h20, 0);
        bus_write(0, 0, 8'h20, 0);
        bus_write(0, 0, 8'h13, 0);
        bus_write(0, 1, 8'h20, 0);
        bus_write(0, 1, 8'h01, 0);
        bus_write(1, 1, 8'hAA, 0);
        bus_write(0, 1, 8'h5A, 1);
        bus_write(0, 0, 8'h0A, 0);
        bus_read(0);

        // reset pulse while WR_n is low: that write must vanish
        CS_n = 1'b0; A0 = 1'b1; D_in = 8'h55; WR_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; WR_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_outputs("mid_wr_reset");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_flag", 8'(cw_flag), 8'd7);
        end
        @(posedge clk);
        #1 CS_n = 1'b1;

        // random traffic
        for (int n = 0; n < 150; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) bus_write(0, 0, 8'($urandom) | 8'h10, 0);
            else if (r <= 5) bus_write($urandom_range(0, 7) == 0, 1'($urandom), 8'($urandom), 0);
            else if (r <= 8) bus_read(1'($urandom));
            else bus_write(0, 1'($urandom), 8'($urandom) & 8'hEF, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
